iterative_divider: RTL and testbench
====================================

# iterative_divider

Multi-cycle radix-2 restoring divider implementing the RISC-V M-extension DIV, DIVU, REM and REMU operations. It sits beside the pipelined multiplier in the execute stage and is the division counterpart of that unit. Unlike the multiplier, it is not pipelined: it accepts one operation at a time through a start/busy/done handshake and stalls the pipeline while busy. Divide-by-zero and signed-overflow cases follow the RISC-V specification and complete early.

## Interface
- WIDTH, 32, operand and result width in bits.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only when the unit can accept (IDLE or DONE).
- op  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  WIDTH  rs1 value; sampled with start.
- divisor  in  WIDTH  rs2 value; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  WIDTH  quotient or remainder; held until the next accepted start.

## Operation
- FSM states are IDLE, CALC and DONE.
  - IDLE → CALC on start, for a normal operation.
  - IDLE → DONE on start, for a special case.
  - CALC → DONE when the iteration counter reaches 0.
  - DONE → IDLE, or DONE → CALC/DONE if start is asserted (back-to-back accept).
- Outputs are registered: busy = (state==CALC); done = (state==DONE).
- Special cases are detected at accept; no iterations run.
  - Divisor 0: quotient is all-ones; remainder is the dividend, for both signed and unsigned ops.
  - Signed overflow (DIV/REM, dividend = 1<<(WIDTH-1), divisor all-ones): quotient is the dividend; remainder is 0.
- Signed ops: divide the absolute values unsigned.
  - Negate the quotient if the operand signs differ.
  - Give the remainder the sign of the dividend.
  - Record the negate flags at accept.
- Iteration (restoring algorithm):
  - Keep a WIDTH+1-bit partial remainder.
  - Shift in the next dividend MSB, then trial-subtract the divisor.
  - If the difference is non-negative, keep it and shift a 1 into the quotient; otherwise shift a 0.
  - Exactly WIDTH iterations; a counter loads WIDTH and decrements.
- Sign fixup and the quotient/remainder select happen on the CALC→DONE edge, registered into result.
- start while in CALC is ignored; the operands are not re-sampled.
- rst at any time returns the unit to IDLE with busy=0, done=0 and result=0, and cancels any in-flight operation.

## Timing
- Reset values: busy=0, done=0, result=0; FSM in IDLE; counter and internal registers 0.
- Let the start sample edge be cycle 0.
- Normal op:
  - busy=1 in cycles 1..WIDTH.
  - done=1 and result valid in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Special case: done=1 in cycle 1; busy stays 0.
- Throughput: a start accepted in the DONE cycle begins the next operation immediately, giving one operation per WIDTH+1 cycles.
- result changes only on the edge that enters DONE, or on reset.

## Structure
- Shared package riscv_muldiv_pkg holds:
  - op encodings OP_DIV, OP_DIVU, OP_REM, OP_REMU;
  - the FSM state enum;
  - the special-case constants (all-ones quotient, signed-minimum pattern), parameterised by WIDTH.
- One sub-module, div_step: a combinational single iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- Sign handling, counter and FSM live in iterative_divider.

## Test plan
- DIVU 100/7 → result 14, done in cycle 33, busy high in cycles 1–32; REMU 100/7 → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1); REM 7/0xFFFFFFFE (−2) → 1.
- Divide-by-zero:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0xFFFFFFFB/0 → 0xFFFFFFFF.
  - Each has done in cycle 1 and busy never high.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; done in cycle 1.
- Handshake:
  - Change the operands and assert start in cycle 10 of CALC → ignored; the result is unchanged and done still arrives in cycle 33.
  - Assert start in the DONE cycle with DIVU 9/3 → busy in the next cycle, result 3 exactly 33 cycles later.
- Reset: assert rst in cycle 10 of a DIVU 100/7 → busy=0, done stays 0, result=0; a subsequent DIVU 50/5 → 10.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide execute units.
package riscv_muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Special-case patterns; callers truncate to their own operand width.
  function automatic logic [63:0] all_ones(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic logic [63:0] signed_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import riscv_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             quot_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             neg_s;

  assign shifted_s = {rem_in, dividend_bit};
  assign neg_s     = (shifted_s < {2'b00, divisor});
  assign diff_s    = shifted_s[WIDTH:0] - {1'b0, divisor};
  assign rem_out   = neg_s ? shifted_s[WIDTH:0] : diff_s;
  assign quot_bit  = ~neg_s;

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU with start/busy/done handshake.
module iterative_divider
  import riscv_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CNT_W        = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD_C   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST_C   = CNT_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES_C   = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] SIGNED_MIN_C = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] ZERO_C       = {WIDTH{1'b0}};

  div_state_e       state_r, state_next_s;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic [WIDTH:0]   rem_r, rem_next_s, step_rem_s;
  logic [WIDTH-1:0] quot_r, quot_next_s, divisor_r, divisor_next_s, result_next_s;
  logic             neg_q_r, neg_q_next_s, neg_r_r, neg_r_next_s, is_rem_r, is_rem_next_s;
  logic             step_qbit_s, signed_s, is_rem_s, a_neg_s, b_neg_s, overflow_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s, fin_quot_s, fin_rem_s;

  assign signed_s   = (op == OP_DIV) || (op == OP_REM);
  assign is_rem_s   = (op == OP_REM) || (op == OP_REMU);
  assign a_neg_s    = signed_s & dividend[WIDTH-1];
  assign b_neg_s    = signed_s & divisor[WIDTH-1];
  assign abs_a_s    = a_neg_s ? (ZERO_C - dividend) : dividend;
  assign abs_b_s    = b_neg_s ? (ZERO_C - divisor) : divisor;
  assign overflow_s = signed_s && (dividend == SIGNED_MIN_C) && (divisor == ALL_ONES_C);

  // quot_r holds the unconsumed dividend bits at the top and the growing quotient at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_r),
    .dividend_bit (quot_r[WIDTH-1]),
    .divisor      (divisor_r),
    .rem_out      (step_rem_s),
    .quot_bit     (step_qbit_s)
  );

  assign fin_quot_s = {quot_r[WIDTH-2:0], step_qbit_s};
  assign fin_rem_s  = step_rem_s[WIDTH-1:0];

  // Next-state, operand capture, iteration and final sign fixup.
  always_comb begin
    state_next_s   = state_r;
    count_next_s   = count_r;
    rem_next_s     = rem_r;
    quot_next_s    = quot_r;
    divisor_next_s = divisor_r;
    neg_q_next_s   = neg_q_r;
    neg_r_next_s   = neg_r_r;
    is_rem_next_s  = is_rem_r;
    result_next_s  = result;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          is_rem_next_s = is_rem_s;
          if (divisor == ZERO_C) begin
            state_next_s  = ST_DONE;
            result_next_s = is_rem_s ? dividend : ALL_ONES_C;
          end else if (overflow_s) begin
            state_next_s  = ST_DONE;
            result_next_s = is_rem_s ? ZERO_C : dividend;
          end else begin
            state_next_s   = ST_CALC;
            count_next_s   = CNT_LOAD_C;
            rem_next_s     = {(WIDTH+1){1'b0}};
            quot_next_s    = abs_a_s;
            divisor_next_s = abs_b_s;
            neg_q_next_s   = a_neg_s ^ b_neg_s;
            neg_r_next_s   = a_neg_s;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        rem_next_s   = step_rem_s;
        quot_next_s  = fin_quot_s;
        count_next_s = count_r - CNT_LAST_C;
        if (count_r == CNT_LAST_C) begin
          state_next_s  = ST_DONE;
          result_next_s = is_rem_r ? (neg_r_r ? (ZERO_C - fin_rem_s) : fin_rem_s)
                                   : (neg_q_r ? (ZERO_C - fin_quot_s) : fin_quot_s);
        end else begin
          state_next_s = ST_CALC;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= {CNT_W{1'b0}};
      rem_r     <= {(WIDTH+1){1'b0}};
      quot_r    <= ZERO_C;
      divisor_r <= ZERO_C;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      is_rem_r  <= 1'b0;
      result    <= ZERO_C;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      count_r   <= count_next_s;
      rem_r     <= rem_next_s;
      quot_r    <= quot_next_s;
      divisor_r <= divisor_next_s;
      neg_q_r   <= neg_q_next_s;
      neg_r_r   <= neg_r_next_s;
      is_rem_r  <= is_rem_next_s;
      result    <= result_next_s;
      busy      <= (state_next_s == ST_CALC);
      done      <= (state_next_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed RISC-V corner cases plus randomized ops vs. an arithmetic model.
module tb_iterative_divider;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int checks_s   = 0;
  int failures_s = 0;

  iterative_divider #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_s++;
    if (got !== exp) begin
      failures_s++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics using plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0] == 1'b0) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Called at a negedge; start is sampled on the following posedge (cycle 0).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; dividend = a; divisor = b; start = 1'b1;
  endtask

  // Watches cycles 1..40; returns at the negedge of the done cycle.
  task automatic track(input int inject, output int done_cyc, output int busy_cnt, output logic [31:0] res);
    done_cyc = -1; busy_cnt = 0; res = 32'd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inject) begin
        start = 1'b1; op = 2'($urandom); dividend = $urandom; divisor = $urandom | 32'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = k; res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inject, input bit hold);
    int dc, bc;
    logic [31:0] res, exp;
    bit sp;
    exp = ref_div(o, a, b);
    sp  = is_special(o, a, b);
    launch(o, a, b);
    track(inject, dc, bc, res);
    chk({tag, "_done_cycle"}, 64'(dc), sp ? 64'd1 : 64'(WIDTH + 1));
    chk({tag, "_busy_cycles"}, 64'(bc), sp ? 64'd0 : 64'(WIDTH));
    chk({tag, "_result"}, 64'(res), 64'(exp));
    if (hold) begin
      @(negedge clk);
      chk({tag, "_hold"}, {31'd0, done, result}, {31'd0, 1'b0, exp});
    end
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {30'd0, busy, done, result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 1'b1);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0, 1'b1);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b1);
    run_op("divu_5_0",   2'b01, 32'd5, 32'd0, 0, 1'b1);
    run_op("rem_5_0",    2'b10, 32'd5, 32'd0, 0, 1'b1);
    run_op("div_m5_0",   2'b00, 32'hFFFF_FFFB, 32'd0, 0, 1'b1);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_op("divu_ignore_start", 2'b01, 32'd100, 32'd7, 10, 1'b1);
    run_op("b2b_first",  2'b11, 32'd1000, 32'd33, 0, 1'b0);
    run_op("b2b_divu_9_3", 2'b01, 32'd9, 32'd3, 0, 1'b1);

    // Reset in the middle of a calculation cancels it.
    launch(2'b01, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midcalc_reset", {30'd0, busy, done, result}, 64'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("reset_cancels", 64'(dcount), 64'd0);
    run_op("divu_50_5", 2'b01, 32'd50, 32'd5, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic [1:0]  o;
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d", i), o, a, b, 0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
